// File: rtl/n64adv2_dram_arbiter_pkg.sv
// rtl/n64adv2_dram_arbiter_pkg.sv - shared encodings and refresh defaults for the DRAM arbiter
package n64adv2_dram_arbiter_pkg;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_REF = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    // 7.8 us average refresh period at each supported DRAM clock
    localparam int REF_INTERVAL_50MHZ  = 390;
    localparam int REF_INTERVAL_100MHZ = 780;
    localparam int REF_INTERVAL_133MHZ = 1037;

endpackage

// File: rtl/n64adv2_dram_refresh_sched.sv
// rtl/n64adv2_dram_refresh_sched.sv - refresh interval timer with saturating pending-refresh count
module n64adv2_dram_refresh_sched #(
    parameter int REF_INTERVAL = 780,
    parameter int MAX_REF_PEND = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic ref_grant,
    output logic ref_pend_nz,
    output logic ref_urgent,
    output logic ref_overrun
);

    localparam int CNT_W  = ($clog2(REF_INTERVAL) > 0) ? $clog2(REF_INTERVAL) : 1;
    localparam int PEND_W = $clog2(MAX_REF_PEND + 1);
    localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(REF_INTERVAL - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_REF_PEND);

    logic [CNT_W-1:0]  interval_cnt;
    logic [PEND_W-1:0] ref_pend;
    logic              tick;

    assign tick        = (interval_cnt == '0);
    assign ref_pend_nz = (ref_pend != '0);
    assign ref_urgent  = (ref_pend == PEND_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            interval_cnt <= RELOAD;
            ref_pend     <= '0;
            ref_overrun  <= 1'b0;
        end else begin
            interval_cnt <= tick ? RELOAD : interval_cnt - CNT_W'(1);
            if (tick && ref_pend == PEND_MAX)
                ref_overrun <= 1'b1;
            // a tick and a grant in the same cycle cancel out
            if (tick && !ref_grant && ref_pend != PEND_MAX)
                ref_pend <= ref_pend + PEND_W'(1);
            else if (!tick && ref_grant)
                ref_pend <= ref_pend - PEND_W'(1);
        end
    end

endmodule

// File: rtl/n64adv2_dram_arbiter.sv
// rtl/n64adv2_dram_arbiter.sv - schedules scaler read/write bursts and refresh onto the shared SDRAM
module n64adv2_dram_arbiter
    import n64adv2_dram_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 22,
    parameter int LEN_W         = 4,
    parameter int REF_INTERVAL  = REF_INTERVAL_100MHZ,
    parameter int MAX_REF_PEND  = 4,
    parameter int MAX_RD_STREAK = 3
) (
    input  logic              DRAM_CLK_i,
    input  logic              DRAM_nRST_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    output logic              rd_gnt_o,
    output logic              rd_done_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LEN_W-1:0]  wr_len_i,
    output logic              wr_gnt_o,
    output logic              wr_done_o,
    output logic              mem_cmd_valid_o,
    input  logic              mem_cmd_ready_i,
    output logic [1:0]        mem_cmd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LEN_W-1:0]  mem_len_o,
    input  logic              mem_done_i,
    output logic              ref_overrun_o
);

    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

    logic [1:0]          state;
    logic [1:0]          cur_cmd;
    logic [STREAK_W-1:0] rd_streak;
    logic [1:0]          sel_cmd;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;
    logic                ref_pend_nz;
    logic                ref_urgent;
    logic                ref_grant;

    n64adv2_dram_refresh_sched #(
        .REF_INTERVAL(REF_INTERVAL),
        .MAX_REF_PEND(MAX_REF_PEND)
    ) u_refresh_sched (
        .clk        (DRAM_CLK_i),
        .resetn     (DRAM_nRST_i),
        .ref_grant  (ref_grant),
        .ref_pend_nz(ref_pend_nz),
        .ref_urgent (ref_urgent),
        .ref_overrun(ref_overrun_o)
    );

    // urgent refresh first, then a starved write, then reads, writes, lazy refresh
    always_comb begin
        sel_cmd = CMD_NOP;
        if (state == ST_IDLE) begin
            if (ref_urgent)                              sel_cmd = CMD_REF;
            else if (wr_req_i && rd_streak >= STREAK_MAX) sel_cmd = CMD_WR;
            else if (rd_req_i)                           sel_cmd = CMD_RD;
            else if (wr_req_i)                           sel_cmd = CMD_WR;
            else if (ref_pend_nz)                        sel_cmd = CMD_REF;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        if (sel_cmd == CMD_RD) begin
            sel_addr = rd_addr_i;
            sel_len  = rd_len_i;
        end else if (sel_cmd == CMD_WR) begin
            sel_addr = wr_addr_i;
            sel_len  = wr_len_i;
        end
    end

    assign ref_grant = (sel_cmd == CMD_REF);

    always_ff @(posedge DRAM_CLK_i) begin
        if (!DRAM_nRST_i) begin
            state           <= ST_IDLE;
            cur_cmd         <= CMD_NOP;
            rd_streak       <= '0;
            rd_gnt_o        <= 1'b0;
            wr_gnt_o        <= 1'b0;
            rd_done_o       <= 1'b0;
            wr_done_o       <= 1'b0;
            mem_cmd_valid_o <= 1'b0;
            mem_cmd_o       <= CMD_NOP;
            mem_addr_o      <= '0;
            mem_len_o       <= '0;
        end else begin
            rd_gnt_o  <= 1'b0;
            wr_gnt_o  <= 1'b0;
            rd_done_o <= 1'b0;
            wr_done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_cmd != CMD_NOP) begin
                        state           <= ST_ISSUE;
                        cur_cmd         <= sel_cmd;
                        mem_cmd_valid_o <= 1'b1;
                        mem_cmd_o       <= sel_cmd;
                        mem_addr_o      <= sel_addr;
                        mem_len_o       <= sel_len;
                        rd_gnt_o        <= (sel_cmd == CMD_RD);
                        wr_gnt_o        <= (sel_cmd == CMD_WR);
                        if (sel_cmd == CMD_RD && rd_streak < STREAK_MAX)
                            rd_streak <= rd_streak + STREAK_W'(1);
                        else if (sel_cmd == CMD_WR)
                            rd_streak <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_cmd_ready_i) begin
                        mem_cmd_valid_o <= 1'b0;
                        mem_cmd_o       <= CMD_NOP;
                        state           <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_done_i) begin
                        rd_done_o <= (cur_cmd == CMD_RD);
                        wr_done_o <= (cur_cmd == CMD_WR);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
